// File: rtl/mult_bus_if.sv
// Bus between mult_bus_master and the memory-mapped multiplier peripheral.
// The master drives cs/addr/rd/wr/bus_wdata; the peripheral returns bus_rdata
// in the cycle that follows a read strobe.
interface mult_bus_if;
   logic        cs;
   logic [4:0]  addr;
   logic        rd;
   logic        wr;
   logic [15:0] bus_wdata;
   logic [31:0] bus_rdata;

   modport master (output cs, addr, rd, wr, bus_wdata, input bus_rdata);
   modport slave  (input cs, addr, rd, wr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/mult_bus_master.sv
// mult_bus_master: runs one complete multiplier job per accepted start pulse.
// The job is write A, write B, set INIT, clear INIT, poll DONE, read RESULT.
// Every access is one strobe cycle followed by GAP idle bus cycles.
// Optional feature macro: MULT_MASTER_TIMEOUT_EN. When it is defined, the job
// aborts with err=1 after MAX_POLLS failed DONE polls.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for start; operands captured on acceptance
// S_WR_A     | write op_a to A (0x04)
// S_WR_B     | write op_b to B (0x08)
// S_INIT_SET | write 0x0001 to INIT (0x0C)
// S_INIT_CLR | write 0x0000 to INIT (0x0C)
// S_POLL     | read DONE (0x10); repeat until bit 0 is set
// S_RES      | read RESULT (0x14) into result
// S_FIN      | one-cycle done pulse, then back to idle
module mult_bus_master #(
   parameter int unsigned GAP       = 1,
   parameter int unsigned MAX_POLLS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        err,
   mult_bus_if.master  bus
);

   localparam logic [4:0] ADDR_A    = 5'h04;
   localparam logic [4:0] ADDR_B    = 5'h08;
   localparam logic [4:0] ADDR_INIT = 5'h0C;
   localparam logic [4:0] ADDR_DONE = 5'h10;
   localparam logic [4:0] ADDR_RES  = 5'h14;

   // The gap timer is loaded with GAP in the strobe cycle and counts down to
   // zero in the last gap cycle, so GAP-1 marks the first gap cycle.
   localparam logic [3:0] GAP_LOAD  = 4'(GAP);
   localparam logic [3:0] GAP_FIRST = 4'(GAP - 1);

   if (GAP < 1 || GAP > 15) begin : g_bad_gap
      $error("mult_bus_master: GAP must be in 1..15");
   end
   if (MAX_POLLS < 1) begin : g_bad_max_polls
      $error("mult_bus_master: MAX_POLLS must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_A,
      S_WR_B,
      S_INIT_SET,
      S_INIT_CLR,
      S_POLL,
      S_RES,
      S_FIN
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  gap_q, gap_d;
   logic        hit_q, hit_d;
   logic [15:0] b_q, b_d;
   logic        cs_q, cs_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [4:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] result_q, result_d;
   logic        enter;
   logic        first_gap;
   logic        last_gap;
   logic        poll_set;

`ifdef MULT_MASTER_TIMEOUT_EN
   localparam int unsigned        CNT_W    = $clog2(MAX_POLLS + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_POLLS - 1);
   logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
   logic             err_q, err_d;
`endif

   assign first_gap = (gap_q == GAP_FIRST);
   assign last_gap  = (gap_q == 4'd0);
   // With GAP=1 the decision edge is also the sampling edge, so take the bus
   // directly; with longer gaps use the value captured in the first gap cycle.
   assign poll_set  = first_gap ? bus.bus_rdata[0] : hit_q;

   // Next-state sequencing and registered-output decode for the next cycle.
   always_comb begin
      state_d  = state_q;
      gap_d    = (gap_q != 4'd0) ? gap_q - 4'd1 : gap_q;
      hit_d    = hit_q;
      b_d      = b_q;
      result_d = result_q;
      enter    = 1'b0;
      cs_d     = 1'b0;
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      addr_d   = 5'd0;
      wdata_d  = 16'd0;
      done_d   = 1'b0;
`ifdef MULT_MASTER_TIMEOUT_EN
      poll_cnt_d = poll_cnt_q;
      err_d      = err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WR_A;
               enter   = 1'b1;
               b_d     = op_b;
`ifdef MULT_MASTER_TIMEOUT_EN
               poll_cnt_d = '0;
               err_d      = 1'b0;
`endif
            end
         end
         S_WR_A: begin
            if (last_gap) begin
               state_d = S_WR_B;
               enter   = 1'b1;
            end
         end
         S_WR_B: begin
            if (last_gap) begin
               state_d = S_INIT_SET;
               enter   = 1'b1;
            end
         end
         S_INIT_SET: begin
            if (last_gap) begin
               state_d = S_INIT_CLR;
               enter   = 1'b1;
            end
         end
         S_INIT_CLR: begin
            if (last_gap) begin
               state_d = S_POLL;
               enter   = 1'b1;
            end
         end
         S_POLL: begin
            if (first_gap) begin
               hit_d = bus.bus_rdata[0];
            end
            // A miss re-enters S_POLL, which issues a fresh DONE read.
            if (last_gap) begin
               enter = 1'b1;
               if (poll_set) begin
                  state_d = S_RES;
               end
`ifdef MULT_MASTER_TIMEOUT_EN
               else if (poll_cnt_q == CNT_LAST) begin
                  state_d  = S_FIN;
                  err_d    = 1'b1;
                  result_d = 32'd0;
               end
               else begin
                  poll_cnt_d = poll_cnt_q + 1'b1;
               end
`endif
            end
         end
         S_RES: begin
            if (first_gap) begin
               result_d = bus.bus_rdata;
            end
            if (last_gap) begin
               state_d = S_FIN;
               enter   = 1'b1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);

      if (enter) begin
         gap_d = GAP_LOAD;
         case (state_d)
            S_WR_A: begin
               cs_d    = 1'b1;
               wr_d    = 1'b1;
               addr_d  = ADDR_A;
               wdata_d = op_a;
            end
            S_WR_B: begin
               cs_d    = 1'b1;
               wr_d    = 1'b1;
               addr_d  = ADDR_B;
               wdata_d = b_q;
            end
            S_INIT_SET: begin
               cs_d    = 1'b1;
               wr_d    = 1'b1;
               addr_d  = ADDR_INIT;
               wdata_d = 16'h0001;
            end
            S_INIT_CLR: begin
               cs_d    = 1'b1;
               wr_d    = 1'b1;
               addr_d  = ADDR_INIT;
               wdata_d = 16'h0000;
            end
            S_POLL: begin
               cs_d   = 1'b1;
               rd_d   = 1'b1;
               addr_d = ADDR_DONE;
            end
            S_RES: begin
               cs_d   = 1'b1;
               rd_d   = 1'b1;
               addr_d = ADDR_RES;
            end
            S_FIN: begin
               done_d = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // State, gap timer and all outputs are registered; reset idles the bus at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         gap_q    <= 4'd0;
         hit_q    <= 1'b0;
         b_q      <= 16'd0;
         cs_q     <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= 5'd0;
         wdata_q  <= 16'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         gap_q    <= gap_d;
         hit_q    <= hit_d;
         b_q      <= b_d;
         cs_q     <= cs_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

`ifdef MULT_MASTER_TIMEOUT_EN
   // Failed-poll counter and timeout flag for the abort path.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         poll_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         poll_cnt_q <= poll_cnt_d;
         err_q      <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign bus.cs        = cs_q;
   assign bus.rd        = rd_q;
   assign bus.wr        = wr_q;
   assign bus.addr      = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign result        = result_q;

endmodule

// File: tb/tb_mult_bus_master.sv
// Bench for mult_bus_master: a GAP=1 instance with a multiplier peripheral model
// whose DONE bit rises on a chosen poll, and a GAP=3 instance with a first-poll
// peripheral. Expected bus traffic, timing and products come from the job rules.
module tb_mult_bus_master;

   localparam int MAXP = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start, start3;
   logic [15:0] op_a, op_b, op_a3, op_b3;
   logic        busy, done, err, busy3, done3, err3;
   logic [31:0] result, result3;

   mult_bus_if bus ();
   mult_bus_if bus3 ();

   mult_bus_master #(.GAP(1), .MAX_POLLS(MAXP)) u_dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .result(result), .err(err), .bus(bus)
   );

   mult_bus_master #(.GAP(3), .MAX_POLLS(MAXP)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .op_a(op_a3), .op_b(op_b3),
      .busy(busy3), .done(done3), .result(result3), .err(err3), .bus(bus3)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Peripheral model, GAP=1 side: DONE reads 1 from poll number hit_on on
   // (0 = never). Read data is valid only in the cycle after the strobe.
   logic [15:0] pa, pb, pa3, pb3;
   logic [31:0] rnd;
   int          hit_on = 1;
   int          poll_seen = 0;

   always @(posedge clk) begin
      rnd = $urandom;
      bus.bus_rdata <= $urandom;
      if (bus.cs && bus.wr) begin
         if (bus.addr == 5'h04) pa <= bus.bus_wdata;
         if (bus.addr == 5'h08) pb <= bus.bus_wdata;
         if (bus.addr == 5'h0C && bus.bus_wdata[0]) poll_seen <= 0;
      end
      if (bus.cs && bus.rd) begin
         if (bus.addr == 5'h10) begin
            poll_seen <= poll_seen + 1;
            bus.bus_rdata <= {rnd[31:1], (hit_on != 0 && poll_seen + 1 >= hit_on)};
         end else if (bus.addr == 5'h14) begin
            bus.bus_rdata <= 32'(pa) * 32'(pb);
         end
      end
   end

   // Peripheral model, GAP=3 side: DONE is set on the first poll.
   always @(posedge clk) begin
      bus3.bus_rdata <= $urandom;
      if (bus3.cs && bus3.wr && bus3.addr == 5'h04) pa3 <= bus3.bus_wdata;
      if (bus3.cs && bus3.wr && bus3.addr == 5'h08) pb3 <= bus3.bus_wdata;
      if (bus3.cs && bus3.rd) begin
         if (bus3.addr == 5'h10) bus3.bus_rdata <= 32'd1;
         else if (bus3.addr == 5'h14) bus3.bus_rdata <= 32'(pa3) * 32'(pb3);
      end
   end

   // Bus monitor: protocol rules every cycle, and a log of every strobe.
   // Entry: {cycle[15:0], wr, rd, addr[4:0], wdata[15:0]}.
   logic [38:0] obs_q[$];
   logic [20:0] obs3_q[$];
   int          t0 = 0;
   int          t3 = 0;
   bit          mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("proto", 64'({bus.rd & bus.wr,
             !bus.cs && (bus.rd || bus.wr || bus.addr != 5'd0 || bus.bus_wdata != 16'd0)}), 64'd0);
         chk("proto3", 64'({bus3.rd & bus3.wr,
             !bus3.cs && (bus3.rd || bus3.wr || bus3.addr != 5'd0 || bus3.bus_wdata != 16'd0)}), 64'd0);
         if (bus.cs)  obs_q.push_back({16'(cyc - t0), bus.wr, bus.rd, bus.addr, bus.bus_wdata});
         if (bus3.cs) obs3_q.push_back({16'(cyc - t3), bus3.addr});
      end
   end

   function automatic logic [38:0] ent(input int k, input bit w, input logic [4:0] ad,
                                       input logic [15:0] d);
      return {16'(1 + k * 2), w, !w, ad, d};
   endfunction

   // One GAP=1 job. polls = poll number that sees DONE (0 = never, timeout build).
   // inject > 0 pulses start with op_a=2 in that cycle of the job.
   task automatic run_job(input string name, input logic [15:0] a, input logic [15:0] b,
                          input int polls, input int inject, input int idle_after);
      logic [38:0] exp_q[$];
      int          n, k, npoll, expd, drops;
      bit          to;
      to    = (polls == 0);
      npoll = to ? MAXP : polls;
      k = 0;
      exp_q.push_back(ent(k++, 1'b1, 5'h04, a));
      exp_q.push_back(ent(k++, 1'b1, 5'h08, b));
      exp_q.push_back(ent(k++, 1'b1, 5'h0C, 16'h0001));
      exp_q.push_back(ent(k++, 1'b1, 5'h0C, 16'h0000));
      for (int p = 0; p < npoll; p++) exp_q.push_back(ent(k++, 1'b0, 5'h10, 16'h0000));
      if (!to) exp_q.push_back(ent(k++, 1'b0, 5'h14, 16'h0000));
      expd = k * 2 + 1;

      hit_on = polls;
      obs_q.delete();
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b; t0 = cyc;
      @(negedge clk);
      start = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom);
      n = 1;
      drops = 0;
      while (!done && n < 300) begin
         if (!busy) drops++;
         if (n == inject) begin
            start = 1'b1; op_a = 16'h0002;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk({name, ".done_cycle"}, 64'(cyc - t0), 64'(expd));
      chk({name, ".busy_during"}, 64'(drops), 64'd0);
      chk({name, ".busy_at_done"}, 64'(busy), 64'd1);
      chk({name, ".result"}, 64'(result), to ? 64'd0 : 64'(32'(a) * 32'(b)));
      chk({name, ".err"}, 64'(err), 64'(to));
      @(negedge clk);
      chk({name, ".done_pulse"}, 64'({done, busy}), 64'd0);
      repeat (idle_after) @(negedge clk);
      chk({name, ".idle_after"}, 64'(busy), 64'd0);
      chk({name, ".n_access"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk($sformatf("%s.access%0d", name, i), 64'(obs_q[i]), 64'(exp_q[i]));
   endtask

   initial begin
      int          n, seen, npolls;
      logic [15:0] a3, b3;
      logic [4:0]  ad3 [6];
      ad3 = '{5'h04, 5'h08, 5'h0C, 5'h0C, 5'h10, 5'h14};

      start = 1'b0; op_a = 16'd0; op_b = 16'd0;
      start3 = 1'b0; op_a3 = 16'd0; op_b3 = 16'd0;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.host", 64'({busy, done, err, result}), 64'd0);
      chk("reset.bus", 64'({bus.cs, bus.rd, bus.wr, bus.addr, bus.bus_wdata}), 64'd0);
      chk("reset.host3", 64'({busy3, done3, err3, result3}), 64'd0);
      mon_en = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk("idle.no_traffic", 64'({busy, bus.cs}), 64'd0);

      run_job("basic", 16'h0005, 16'h000F, 3, 0, 2);
      run_job("max", 16'hFFFF, 16'hFFFF, 1, 0, 2);
      for (int i = 0; i < 8; i++)
         run_job($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), int'($urandom_range(1, 4)), 0, 1);
      run_job("ignore", 16'h0005, 16'h000F, 3, 5, 20);

      // Reset during the DONE poll strobe, with a nonzero result held from before.
      hit_on = 0;
      @(negedge clk);
      start = 1'b1; op_a = 16'h0003; op_b = 16'h0007; t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(bus.cs && bus.rd && bus.addr == 5'h10) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst.reached_poll", 64'(n < 50), 64'd1);
      rst = 1'b0;
      #1;
      chk("rst.bus", 64'({bus.cs, bus.rd, bus.wr}), 64'd0);
      chk("rst.host", 64'({busy, done}), 64'd0);
      chk("rst.result", 64'(result), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst.stays_idle", 64'({busy, bus.cs}), 64'd0);
      run_job("after_rst", 16'h0003, 16'h0007, 2, 0, 2);

      // start held high: re-accepted in the idle cycle after FIN.
      hit_on = 1;
      @(negedge clk);
      start = 1'b1; op_a = 16'h1234; op_b = 16'h0011; t0 = cyc;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b.done1", 64'(cyc - t0), 64'd13);
      @(negedge clk);
      chk("b2b.idle_gap", 64'(busy), 64'd0);
      @(negedge clk);
      chk("b2b.reaccept", 64'(busy), 64'd1);
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b.done2", 64'(cyc - t0), 64'd27);
      chk("b2b.result", 64'(result), 64'(32'h1234 * 32'h0011));
      @(negedge clk);

      // GAP=3 instance, first-poll hit.
      a3 = 16'($urandom);
      b3 = 16'($urandom);
      obs3_q.delete();
      @(negedge clk);
      start3 = 1'b1; op_a3 = a3; op_b3 = b3; t3 = cyc;
      @(negedge clk);
      start3 = 1'b0;
      n = 1;
      while (!done3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("gap3.done_cycle", 64'(cyc - t3), 64'd25);
      chk("gap3.result", 64'(result3), 64'(32'(a3) * 32'(b3)));
      chk("gap3.n_access", 64'(obs3_q.size()), 64'd6);
      for (int i = 0; i < 6 && i < obs3_q.size(); i++)
         chk($sformatf("gap3.access%0d", i), 64'(obs3_q[i]), 64'({16'(1 + i * 4), ad3[i]}));
      repeat (2) @(negedge clk);

`ifdef MULT_MASTER_TIMEOUT_EN
      run_job("timeout", 16'h1234, 16'h0055, 0, 0, 2);
`else
      hit_on = 0;
      obs_q.delete();
      @(negedge clk);
      start = 1'b1; op_a = 16'h0009; op_b = 16'h0009; t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      repeat (260) begin
         if (done) seen++;
         @(negedge clk);
      end
      npolls = 0;
      foreach (obs_q[k]) if (obs_q[k][21:16] == 6'h30) npolls++;
      chk("no_timeout.polls_over_100", 64'(npolls > 100), 64'd1);
      chk("no_timeout.no_done", 64'(seen), 64'd0);
      chk("no_timeout.busy_err", 64'({busy, err}), 64'b10);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
      $fatal(1);
   end

endmodule
